fir_host_sequencer: RTL and testbench
=====================================

Name: fir_host_sequencer

Overview:
- Initiator side of the FIR accelerator's push/pop FIFO interface: owns the coefficient bank and drives acc_push_coef/acc_push_sample/acc_pop_output.
- Takes one input sample per transaction on a valid/ready stream and reloads all NUM_TAPS coefficients.
- Pushes the sample, waits a fixed result latency, then pops and captures the accelerator result.
- Presents the result on a valid/ready output stream.

Parameters:
- NUM_TAPS, 4, coefficients pushed per transaction (= accelerator DSP block count); range 1..16.
- DATA_W, 8, sample/coefficient/result width.
- RESULT_LATENCY, 4, idle cycles between sample push and pop; ≥1.
- CNT_W, 16, width of result counter.

Ports:
- clk  in  1  clock.
- reset_n  in  1  reset; synchronous, active-low; clock clk.
- coef_wr_en  in  1  coefficient bank write strobe.
- coef_wr_addr  in  4  bank index; indices ≥ NUM_TAPS are ignored.
- coef_wr_data  in  DATA_W  coefficient value.
- s_valid  in  1  input sample valid.
- s_ready  out  1  sequencer can accept a sample.
- s_data  in  DATA_W  input sample.
- acc_push_coef  out  1  push strobe to accelerator coefficient FIFO.
- acc_new_coef  out  DATA_W  coefficient data.
- acc_push_sample  out  1  push strobe to accelerator sample FIFO.
- acc_new_sample  out  DATA_W  sample data.
- acc_pop_output  out  1  pop strobe to accelerator output FIFO.
- acc_data_out  in  DATA_W  accelerator result, registered by the accelerator on the pop edge.
- m_valid  out  1  result valid.
- m_ready  in  1  downstream accepts result.
- m_data  out  DATA_W  result.
- busy  out  1  state != IDLE.
- cfg_err  out  1  sticky; coefficient write dropped while busy.
- result_count  out  CNT_W  results delivered; wraps modulo 2^CNT_W.

Behaviour:
- Reset: all outputs 0, except s_ready=1 once in IDLE. Coefficient bank cleared to 0. State IDLE. Sample latch, tap index and wait counter cleared. Reset mid-transaction aborts immediately with no partial pops. The accelerator shares reset_n, so its FIFOs are also cleared.
- All acc_* and m_* outputs are registered.
- States: IDLE, LOAD_COEF, PUSH_SAMPLE, WAIT, POP, CAPTURE, OUT.
- IDLE: s_ready=1. On s_valid&s_ready, latch s_data, set tap=0, go to LOAD_COEF.
- LOAD_COEF: one cycle per tap. acc_push_coef=1, acc_new_coef=bank[tap], tap order 0..NUM_TAPS-1. After tap NUM_TAPS-1, go to PUSH_SAMPLE.
- PUSH_SAMPLE: one cycle. acc_push_sample=1, acc_new_sample=latched sample. Go to WAIT with counter=RESULT_LATENCY.
- WAIT: all strobes 0. Decrement each cycle; at counter==1, go to POP.
- POP: one cycle, acc_pop_output=1. Go to CAPTURE.
- CAPTURE: one cycle. At its end, m_data <= acc_data_out and m_valid <= 1. Go to OUT.
- OUT: hold m_valid and m_data stable until m_ready. On m_valid&m_ready: m_valid<=0, result_count++, go to IDLE.
- Latency: first acc_push_coef is asserted the cycle after acceptance. m_valid rises NUM_TAPS+RESULT_LATENCY+3 clock edges after the acceptance edge (11 at defaults).
- Throughput: one result per NUM_TAPS+RESULT_LATENCY+5 cycles when m_ready=1. No overlap between transactions.
- Strobes are mutually exclusive, and each is high for exactly the stated cycles.
- Coefficient writes in IDLE take effect at that edge. A write coincident with sample acceptance is used by the ensuing load.
- Coefficient writes while busy are dropped and set cfg_err, which clears only on reset.
- Out-of-range coef_wr_addr is silently ignored and does not set cfg_err.
- s_valid while busy: s_ready=0, so the sample is not consumed; upstream must hold it.

Decomposition:
- Shared package fir_pkg:
  - state enum type fir_seq_state_t;
  - DATA_W default constant;
  - localparam TAP_IDX_W = $clog2(NUM_TAPS) helper function.
- One sub-module: fir_coef_bank (NUM_TAPS x DATA_W register file, synchronous write, combinational read, synchronous clear).

Test Plan:
- Bank = {1,2,3,4}, send sample 5 → acc_push_coef high on 4 consecutive cycles carrying 1,2,3,4. Next cycle acc_push_sample=1 with 5. acc_pop_output exactly 5 cycles after the sample push. With model acc_data_out=0x32, m_data=0x32 and m_valid rise 11 edges after acceptance.
- m_ready low for 5 cycles in OUT → m_valid and m_data held (0x32), s_ready=0, no strobes. On m_ready=1, result_count 0→1 and s_ready=1 next cycle.
- coef_wr_en addr 2 data 0x7F while in WAIT → bank[2] unchanged (3), cfg_err=1 and remains 1 after two further transactions.
- coef_wr_en addr 0 data 9 in the same cycle as s_valid in IDLE → first acc_new_coef=9.
- Reset asserted in WAIT → next cycle all strobes 0, m_valid=0, busy=0, bank all 0. After release, s_ready=1 and no pop is issued.
- Preset result_count to 0xFFFF via 65535 transactions (or force) → next delivery wraps it to 0x0000.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared types and helpers for the FIR host sequencer and its coefficient bank.
package fir_pkg;

    localparam int FIR_DATA_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_COEF,
        PUSH_SAMPLE,
        WAIT,
        POP,
        CAPTURE,
        OUT
    } fir_seq_state_t;

    // Width of a tap index; a single-tap bank still needs one address bit.
    function automatic int tap_idx_w(input int num_taps);
        return (num_taps > 1) ? $clog2(num_taps) : 1;
    endfunction

endpackage

// File: rtl/fir_host_sequencer_if.sv
// Sample/result streams and accelerator push/pop strobes seen by the FIR host sequencer.
interface fir_host_sequencer_if
    import fir_pkg::*;
#(
    parameter int DATA_W = FIR_DATA_W
);
    logic              s_valid;
    logic              s_ready;
    logic [DATA_W-1:0] s_data;
    logic              m_valid;
    logic              m_ready;
    logic [DATA_W-1:0] m_data;
    logic              acc_push_coef;
    logic [DATA_W-1:0] acc_new_coef;
    logic              acc_push_sample;
    logic [DATA_W-1:0] acc_new_sample;
    logic              acc_pop_output;
    logic [DATA_W-1:0] acc_data_out;

    modport master (
        input  s_valid, s_data, m_ready, acc_data_out,
        output s_ready, m_valid, m_data,
        output acc_push_coef, acc_new_coef, acc_push_sample, acc_new_sample, acc_pop_output
    );

    modport slave (
        output s_valid, s_data, m_ready, acc_data_out,
        input  s_ready, m_valid, m_data,
        input  acc_push_coef, acc_new_coef, acc_push_sample, acc_new_sample, acc_pop_output
    );

endinterface

// File: rtl/fir_coef_bank.sv
// NUM_TAPS x DATA_W coefficient register file: synchronous write/clear, combinational read.
module fir_coef_bank
    import fir_pkg::*;
#(
    parameter int NUM_TAPS = 4,
    parameter int DATA_W   = FIR_DATA_W,
    parameter int ADDR_W   = tap_idx_w(NUM_TAPS)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [NUM_TAPS];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_TAPS; i++) mem[i] <= '0;
        end else if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fir_host_sequencer.sv
// Initiator for the FIR accelerator FIFOs: reloads coefficients, pushes one sample,
// waits a fixed latency, pops the result and offers it on a valid/ready stream.
module fir_host_sequencer
    import fir_pkg::*;
#(
    parameter int NUM_TAPS       = 4,
    parameter int DATA_W         = FIR_DATA_W,
    parameter int RESULT_LATENCY = 4,
    parameter int CNT_W          = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  coef_wr_en,
    input  logic [3:0]            coef_wr_addr,
    input  logic [DATA_W-1:0]     coef_wr_data,
    fir_host_sequencer_if.master  seq_bus,
    output logic                  busy,
    output logic                  cfg_err,
    output logic [CNT_W-1:0]      result_count
);

    localparam int TAP_IDX_W = tap_idx_w(NUM_TAPS);
    localparam int WAIT_W    = $clog2(RESULT_LATENCY + 1);

    fir_seq_state_t       state, next_state;
    logic [TAP_IDX_W-1:0] tap, next_tap;
    logic [WAIT_W-1:0]    cnt, next_cnt;
    logic [DATA_W-1:0]    sample;
    logic                 accept, addr_ok, bank_we, bypass;
    logic [DATA_W-1:0]    bank_rd, coef_sel;
    logic                 push_coef_d, push_sample_d, pop_d, s_ready_d, m_valid_d;
    logic [DATA_W-1:0]    new_coef_d, new_sample_d;

    assign accept  = (state == IDLE) && seq_bus.s_valid && seq_bus.s_ready;
    assign addr_ok = {1'b0, coef_wr_addr} < 5'(NUM_TAPS);
    assign bank_we = coef_wr_en && addr_ok && (state == IDLE);
    // A write landing on the acceptance edge must reach the first pushed coefficient.
    assign bypass   = bank_we && (coef_wr_addr[TAP_IDX_W-1:0] == next_tap);
    assign coef_sel = bypass ? coef_wr_data : bank_rd;
    assign busy     = (state != IDLE);

    fir_coef_bank #(
        .NUM_TAPS (NUM_TAPS),
        .DATA_W   (DATA_W),
        .ADDR_W   (TAP_IDX_W)
    ) u_bank (
        .clk     (clk),
        .reset_n (reset_n),
        .wr_en   (bank_we),
        .wr_addr (coef_wr_addr[TAP_IDX_W-1:0]),
        .wr_data (coef_wr_data),
        .rd_addr (next_tap),
        .rd_data (bank_rd)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state  <= IDLE;
            tap    <= '0;
            cnt    <= '0;
            sample <= '0;
        end else begin
            state <= next_state;
            tap   <= next_tap;
            cnt   <= next_cnt;
            if (accept) sample <= seq_bus.s_data;
        end
    end

    always_comb begin
        next_state = state;
        next_tap   = tap;
        next_cnt   = cnt;
        case (state)
            IDLE: begin
                if (accept) begin
                    next_state = LOAD_COEF;
                    next_tap   = '0;
                end
            end
            LOAD_COEF: begin
                if (tap == TAP_IDX_W'(NUM_TAPS - 1)) next_state = PUSH_SAMPLE;
                else                                 next_tap   = tap + TAP_IDX_W'(1);
            end
            PUSH_SAMPLE: begin
                next_state = WAIT;
                next_cnt   = WAIT_W'(RESULT_LATENCY);
            end
            WAIT: begin
                if (cnt == WAIT_W'(1)) next_state = POP;
                else                   next_cnt   = cnt - WAIT_W'(1);
            end
            POP:     next_state = CAPTURE;
            CAPTURE: next_state = OUT;
            OUT: begin
                if (seq_bus.m_valid && seq_bus.m_ready) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so every strobe comes straight off a flop.
    always_comb begin
        push_coef_d   = (next_state == LOAD_COEF);
        push_sample_d = (next_state == PUSH_SAMPLE);
        pop_d         = (next_state == POP);
        s_ready_d     = (next_state == IDLE);
        m_valid_d     = (next_state == OUT);
        new_coef_d    = push_coef_d ? coef_sel : '0;
        new_sample_d  = push_sample_d ? sample : '0;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            seq_bus.s_ready         <= 1'b1;
            seq_bus.m_valid         <= 1'b0;
            seq_bus.m_data          <= '0;
            seq_bus.acc_push_coef   <= 1'b0;
            seq_bus.acc_new_coef    <= '0;
            seq_bus.acc_push_sample <= 1'b0;
            seq_bus.acc_new_sample  <= '0;
            seq_bus.acc_pop_output  <= 1'b0;
            cfg_err                 <= 1'b0;
            result_count            <= '0;
        end else begin
            seq_bus.s_ready         <= s_ready_d;
            seq_bus.m_valid         <= m_valid_d;
            seq_bus.acc_push_coef   <= push_coef_d;
            seq_bus.acc_new_coef    <= new_coef_d;
            seq_bus.acc_push_sample <= push_sample_d;
            seq_bus.acc_new_sample  <= new_sample_d;
            seq_bus.acc_pop_output  <= pop_d;
            if (state == CAPTURE) seq_bus.m_data <= seq_bus.acc_data_out;
            if (coef_wr_en && addr_ok && (state != IDLE)) cfg_err <= 1'b1;
            if ((state == OUT) && seq_bus.m_valid && seq_bus.m_ready)
                result_count <= result_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_fir_host_sequencer.sv
// Directed and randomized bench for fir_host_sequencer against a behavioural accelerator and bank model.
module tb_fir_host_sequencer;

    localparam int NT = 4;
    localparam int RL = 4;
    localparam int DW = 8;
    localparam int CW = 4;   // narrow counter so the wrap is reachable in a short run

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          coef_wr_en = 1'b0;
    logic [3:0]    coef_wr_addr = '0;
    logic [DW-1:0] coef_wr_data = '0;
    logic          busy, cfg_err;
    logic [CW-1:0] result_count;

    int            checks = 0;
    int            errors = 0;
    logic [DW-1:0] model [NT];
    logic [CW-1:0] exp_count = '0;

    fir_host_sequencer_if #(.DATA_W(DW)) ifc ();

    fir_host_sequencer #(
        .NUM_TAPS       (NT),
        .DATA_W         (DW),
        .RESULT_LATENCY (RL),
        .CNT_W          (CW)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .coef_wr_en   (coef_wr_en),
        .coef_wr_addr (coef_wr_addr),
        .coef_wr_data (coef_wr_data),
        .seq_bus      (ifc.master),
        .busy         (busy),
        .cfg_err      (cfg_err),
        .result_count (result_count)
    );

    always #5 clk = ~clk;

    // Accelerator stand-in: dot product of the pushed coefficients with the pushed sample,
    // registered onto acc_data_out on the pop edge.
    logic [DW-1:0] coef_q [$];
    logic [DW-1:0] acc_res;
    always @(posedge clk) begin
        if (!reset_n) begin
            coef_q.delete();
            acc_res = '0;
            ifc.acc_data_out <= '0;
        end else begin
            if (ifc.acc_push_coef) coef_q.push_back(ifc.acc_new_coef);
            if (ifc.acc_push_sample) begin
                acc_res = '0;
                foreach (coef_q[i]) acc_res = acc_res + DW'(coef_q[i] * ifc.acc_new_sample);
                coef_q.delete();
            end
            if (ifc.acc_pop_output) ifc.acc_data_out <= acc_res;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [31:0] strobes();
        return 32'({ifc.acc_push_coef, ifc.acc_push_sample, ifc.acc_pop_output});
    endfunction

    task automatic write_coef(input logic [3:0] addr, input logic [DW-1:0] data);
        coef_wr_en   = 1'b1;
        coef_wr_addr = addr;
        coef_wr_data = data;
        tick();
        coef_wr_en = 1'b0;
        if (int'(addr) < NT) model[addr] = data;
    endtask

    // One full transaction; inj >= 0 drives a busy-time write to addr 2 after that edge.
    task automatic send(input logic [DW-1:0] smp, input int hold, input int inj);
        int            budget;
        logic [DW-1:0] snap [NT];
        logic [DW-1:0] exp_res;
        budget = 0;
        while (!ifc.s_ready && budget < 50) begin
            tick();
            budget++;
        end
        chk("s_ready_wait", 32'(ifc.s_ready), 32'd1);
        snap    = model;
        exp_res = '0;
        for (int i = 0; i < NT; i++) exp_res = exp_res + DW'(snap[i] * smp);
        ifc.s_valid = 1'b1;
        ifc.s_data  = smp;
        tick();
        ifc.s_valid = 1'b0;
        coef_wr_en  = 1'b0;
        ifc.s_data  = DW'($urandom);
        chk("busy_after_accept", 32'(busy), 32'd1);
        for (int e = 0; e <= NT + RL + 2; e++) begin
            if (e < NT) begin
                chk("coef_strobe", strobes(), 32'b100);
                chk("coef_data", 32'(ifc.acc_new_coef), 32'(snap[e]));
            end else if (e == NT) begin
                chk("sample_strobe", strobes(), 32'b010);
                chk("sample_data", 32'(ifc.acc_new_sample), 32'(smp));
            end else if (e <= NT + RL) begin
                chk("wait_strobe", strobes(), 32'b000);
            end else if (e == NT + RL + 1) begin
                chk("pop_strobe", strobes(), 32'b001);
            end else begin
                chk("capture_strobe", strobes(), 32'b000);
                chk("capture_m_valid", 32'(ifc.m_valid), 32'd0);
            end
            if (e == inj) begin
                coef_wr_en   = 1'b1;
                coef_wr_addr = 4'd2;
                coef_wr_data = 8'h7F;
            end
            tick();
            coef_wr_en = 1'b0;
        end
        chk("m_valid_rise", 32'(ifc.m_valid), 32'd1);
        chk("m_data", 32'(ifc.m_data), 32'(exp_res));
        for (int h = 0; h < hold; h++) begin
            tick();
            chk("hold_m_valid", 32'(ifc.m_valid), 32'd1);
            chk("hold_m_data", 32'(ifc.m_data), 32'(exp_res));
            chk("hold_s_ready", 32'(ifc.s_ready), 32'd0);
            chk("hold_strobe", strobes(), 32'b000);
        end
        ifc.m_ready = 1'b1;
        tick();
        ifc.m_ready = 1'b0;
        exp_count   = exp_count + CW'(1);
        chk("result_count", 32'(result_count), 32'(exp_count));
        chk("m_valid_drop", 32'(ifc.m_valid), 32'd0);
        chk("s_ready_return", 32'(ifc.s_ready), 32'd1);
        chk("busy_idle", 32'(busy), 32'd0);
    endtask

    initial begin
        int pops;
        ifc.s_valid = 1'b0;
        ifc.s_data  = '0;
        ifc.m_ready = 1'b0;
        for (int i = 0; i < NT; i++) model[i] = '0;

        // Reset state
        tick();
        tick();
        chk("rst_s_ready", 32'(ifc.s_ready), 32'd1);
        chk("rst_strobes", strobes(), 32'd0);
        chk("rst_m_valid", 32'(ifc.m_valid), 32'd0);
        chk("rst_m_data", 32'(ifc.m_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_cfg_err", 32'(cfg_err), 32'd0);
        chk("rst_count", 32'(result_count), 32'd0);
        reset_n = 1'b1;
        tick();

        // Bank {1,2,3,4}, sample 5, result 0x32 held for 5 cycles
        for (int i = 0; i < NT; i++) write_coef(4'(i), DW'(i + 1));
        send(8'd5, 5, -1);

        // Out-of-range write is ignored without raising cfg_err
        write_coef(4'd9, 8'hAA);
        chk("oor_cfg_err", 32'(cfg_err), 32'd0);

        // Write coincident with acceptance feeds the first pushed coefficient
        coef_wr_en   = 1'b1;
        coef_wr_addr = 4'd0;
        coef_wr_data = 8'd9;
        model[0]     = 8'd9;
        send(DW'($urandom), 0, -1);

        // Write during WAIT is dropped and latches cfg_err
        send(DW'($urandom), 1, NT + 2);
        chk("busy_wr_cfg_err", 32'(cfg_err), 32'd1);
        send(DW'($urandom), 0, -1);
        send(DW'($urandom), 2, -1);
        chk("cfg_err_sticky", 32'(cfg_err), 32'd1);

        // Randomized writes (some out of range) and transactions
        for (int t = 0; t < 8; t++) begin
            write_coef(4'($urandom_range(0, 15)), DW'($urandom));
            send(DW'($urandom), int'($urandom_range(0, 3)), -1);
        end
        chk("cfg_err_after_rand", 32'(cfg_err), 32'd1);

        // Reset asserted while waiting for the result
        ifc.s_valid = 1'b1;
        ifc.s_data  = 8'h11;
        tick();
        ifc.s_valid = 1'b0;
        repeat (NT + 2) tick();
        chk("pre_reset_busy", 32'(busy), 32'd1);
        reset_n = 1'b0;
        tick();
        chk("abort_strobes", strobes(), 32'd0);
        chk("abort_m_valid", 32'(ifc.m_valid), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_cfg_err", 32'(cfg_err), 32'd0);
        chk("abort_count", 32'(result_count), 32'd0);
        reset_n = 1'b1;
        tick();
        chk("post_reset_s_ready", 32'(ifc.s_ready), 32'd1);
        pops = 0;
        for (int c = 0; c < 2 * RL + 4; c++) begin
            if (ifc.acc_pop_output) pops++;
            tick();
        end
        chk("no_pop_after_abort", 32'(pops), 32'd0);
        for (int i = 0; i < NT; i++) model[i] = '0;
        exp_count = '0;
        send(DW'($urandom), 0, -1);

        // Drive the result counter around its wrap point
        while (exp_count != {CW{1'b1}}) begin
            write_coef(4'($urandom_range(0, NT - 1)), DW'($urandom));
            send(DW'($urandom), 0, -1);
        end
        send(DW'($urandom), 1, -1);
        chk("count_wrap", 32'(result_count), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "bench did not complete");
    end

endmodule
